fixed_point_fft_stage_feeder: RTL and testbench

- Sequential staging block that sits directly upstream of the combinational fixed-point butterfly array (b lanes).
- Collects one frame of N complex fixed-point samples serially over a val/rdy stream and buffers it.
- Then issues the frame as radix-2 DIT butterfly operand pairs for one compile-time stage, b pairs per beat, each with its twiddle index.
- Twiddle values come from an external ROM addressed by widx; this block only computes the index.

---
 rtl/fixed_point_fft_stage_feeder_if.sv | 31 +++
 rtl/fixed_point_fft_stage_feeder.sv | 140 ++++++++++++++
 tb/tb_fixed_point_fft_stage_feeder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_fft_stage_feeder_if.sv
// Sample stream in, butterfly operand beats out, for the FFT stage feeder.
// The feeder uses the slave modport; the surrounding environment uses master.
interface fixed_point_fft_stage_feeder_if #(
    parameter int n = 32,
    parameter int N = 8,
    parameter int b = 2
);
    localparam int WW = (N > 2) ? $clog2(N / 2) : 1;

    logic          recv_val;
    logic          recv_rdy;
    logic [n-1:0]  recv_r;
    logic [n-1:0]  recv_c;
    logic          send_val;
    logic          send_rdy;
    logic [n-1:0]  ar   [b];
    logic [n-1:0]  ac   [b];
    logic [n-1:0]  br   [b];
    logic [n-1:0]  bc   [b];
    logic [WW-1:0] widx [b];

    modport master (
        output recv_val, recv_r, recv_c, send_rdy,
        input  recv_rdy, send_val, ar, ac, br, bc, widx
    );

    modport slave (
        input  recv_val, recv_r, recv_c, send_rdy,
        output recv_rdy, send_val, ar, ac, br, bc, widx
    );
endinterface

// File: rtl/fixed_point_fft_stage_feeder.sv
// Buffers one N-sample complex frame, then issues it as radix-2 DIT butterfly
// operand pairs for stage STAGE, b pairs per beat, with their twiddle indices.
module fixed_point_fft_stage_feeder #(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter int N     = 8,
    parameter int b     = 2,
    parameter int STAGE = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    fixed_point_fft_stage_feeder_if.slave bus
);
    localparam int LOGN = $clog2(N);
    localparam int H    = 1 << STAGE;
    localparam int NB   = N / (2 * b);
    localparam int LW   = LOGN;
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int WW   = (N > 2) ? $clog2(N / 2) : 1;

    if ((N < 2) || ((N & (N - 1)) != 0) || (b < 1) || (((N / 2) % b) != 0) ||
        (STAGE < 0) || (STAGE >= LOGN) || (d > n)) begin : g_bad_params
        $error("fixed_point_fft_stage_feeder: unsupported parameter set");
    end

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [LW-1:0] load_cnt_r;
    logic [LW-1:0] load_cnt_s;
    logic [BW-1:0] beat_cnt_r;
    logic [BW-1:0] beat_cnt_s;
    logic [n-1:0]  buf_re_r [N];
    logic [n-1:0]  buf_im_r [N];
    logic [LW-1:0] top_s    [b];
    logic [LW-1:0] bot_s    [b];
    logic [WW-1:0] widx_s   [b];

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= LOAD;
            load_cnt_r <= {LW{1'b0}};
            beat_cnt_r <= {BW{1'b0}};
        end else begin
            state_r    <= state_s;
            load_cnt_r <= load_cnt_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

    // Frame buffer capture; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == LOAD) && bus.recv_val) begin
            buf_re_r[load_cnt_r] <= bus.recv_r;
            buf_im_r[load_cnt_r] <= bus.recv_c;
        end
    end

    // Next-state logic: the last sample or the last beat flips phase on the same edge.
    always_comb begin
        state_s    = state_r;
        load_cnt_s = load_cnt_r;
        beat_cnt_s = beat_cnt_r;
        case (state_r)
            LOAD: begin
                if (bus.recv_val) begin
                    if (load_cnt_r == LW'(N - 1)) begin
                        state_s    = EMIT;
                        load_cnt_s = {LW{1'b0}};
                    end else begin
                        load_cnt_s = load_cnt_r + LW'(1);
                    end
                end else begin
                    load_cnt_s = load_cnt_r;
                end
            end
            EMIT: begin
                if (bus.send_rdy) begin
                    if (beat_cnt_r == BW'(NB - 1)) begin
                        state_s    = LOAD;
                        beat_cnt_s = {BW{1'b0}};
                    end else begin
                        beat_cnt_s = beat_cnt_r + BW'(1);
                    end
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s    = LOAD;
                load_cnt_s = {LW{1'b0}};
                beat_cnt_s = {BW{1'b0}};
            end
        endcase
    end

    // Pair j splits into group g and offset p; H is a power of two so these are shifts/masks.
    always_comb begin : pair_index
        int j;
        int g;
        int p;
        j = 0;
        g = 0;
        p = 0;
        for (int i = 0; i < b; i++) begin
            j         = (int'(beat_cnt_r) * b) + i;
            g         = j / H;
            p         = j % H;
            top_s[i]  = LW'((2 * H * g) + p);
            bot_s[i]  = LW'((2 * H * g) + p + H);
            widx_s[i] = WW'(p * (N / (2 * H)));
        end
    end

    // Handshake flags and operand outputs, forced to zero outside EMIT.
    always_comb begin
        bus.recv_rdy = (state_r == LOAD);
        bus.send_val = (state_r == EMIT);
        for (int i = 0; i < b; i++) begin
            if (state_r == EMIT) begin
                bus.ar[i]   = buf_re_r[top_s[i]];
                bus.ac[i]   = buf_im_r[top_s[i]];
                bus.br[i]   = buf_re_r[bot_s[i]];
                bus.bc[i]   = buf_im_r[bot_s[i]];
                bus.widx[i] = widx_s[i];
            end else begin
                bus.ar[i]   = {n{1'b0}};
                bus.ac[i]   = {n{1'b0}};
                bus.br[i]   = {n{1'b0}};
                bus.bc[i]   = {n{1'b0}};
                bus.widx[i] = {WW{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_fft_stage_feeder.sv
// Bench: three N=8,b=2 feeders (STAGE 0,1,2) driven in lockstep plus one N=2,b=1
// feeder, each checked against a pair-enumeration reference model.
module tb_fixed_point_fft_stage_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        recv_val;
    logic [31:0] recv_r;
    logic [31:0] recv_c;
    logic        send_rdy;
    logic        recv_rdy8 [3];
    logic        send_val8 [3];
    logic [31:0] o_ar [3][2];
    logic [31:0] o_ac [3][2];
    logic [31:0] o_br [3][2];
    logic [31:0] o_bc [3][2];
    logic [1:0]  o_w  [3][2];
    logic [31:0] fr_r [8];
    logic [31:0] fr_c [8];
    int checks = 0;
    int errors = 0;

    for (genvar s = 0; s < 3; s++) begin : g_st
        fixed_point_fft_stage_feeder_if #(.n(32), .N(8), .b(2)) bus ();
        fixed_point_fft_stage_feeder #(.n(32), .d(16), .N(8), .b(2), .STAGE(s)) dut (
            .clk(clk), .reset(reset), .bus(bus.slave));
        assign bus.recv_val = recv_val;
        assign bus.recv_r   = recv_r;
        assign bus.recv_c   = recv_c;
        assign bus.send_rdy = send_rdy;
        assign recv_rdy8[s] = bus.recv_rdy;
        assign send_val8[s] = bus.send_val;
        for (genvar i = 0; i < 2; i++) begin : g_ln
            assign o_ar[s][i] = bus.ar[i];
            assign o_ac[s][i] = bus.ac[i];
            assign o_br[s][i] = bus.br[i];
            assign o_bc[s][i] = bus.bc[i];
            assign o_w[s][i]  = bus.widx[i];
        end
    end

    fixed_point_fft_stage_feeder_if #(.n(32), .N(2), .b(1)) bus2 ();
    fixed_point_fft_stage_feeder #(.n(32), .d(16), .N(2), .b(1), .STAGE(0)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    // Reference: list butterflies group by group, offset by offset; beat t lane i is entry t*b+i.
    function automatic void model_pair(input int stage, input int j,
                                       output int top, output int bot, output int w);
        int tq[$];
        int bq[$];
        int wq[$];
        int h;
        h = 1 << stage;
        for (int base = 0; base < 8; base += 2 * h) begin
            for (int p = 0; p < h; p++) begin
                tq.push_back(base + p);
                bq.push_back(base + p + h);
                wq.push_back(p * (8 / (2 * h)));
            end
        end
        top = tq[j];
        bot = bq[j];
        w   = wq[j];
    endfunction

    task automatic check_idle8(input string name);
        for (int s = 0; s < 3; s++) begin
            bit zero;
            zero = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (o_ar[s][i] !== 32'd0 || o_ac[s][i] !== 32'd0 || o_br[s][i] !== 32'd0 ||
                    o_bc[s][i] !== 32'd0 || o_w[s][i] !== 2'd0) zero = 1'b0;
            end
            checks++;
            if (recv_rdy8[s] !== 1'b1 || send_val8[s] !== 1'b0 || !zero) begin
                errors++;
                $display("FAIL %s stage%0d: got recv_rdy=%b send_val=%b outputs_zero=%b, want 1 0 1",
                         name, s, recv_rdy8[s], send_val8[s], zero);
            end
        end
    endtask

    task automatic check_beat8(input int beat);
        int top, bot, w;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 2; i++) begin
                model_pair(s, beat * 2 + i, top, bot, w);
                checks++;
                if (o_ar[s][i] !== fr_r[top] || o_ac[s][i] !== fr_c[top] ||
                    o_br[s][i] !== fr_r[bot] || o_bc[s][i] !== fr_c[bot] || o_w[s][i] !== 2'(w)) begin
                    errors++;
                    $display("FAIL beat stage%0d beat%0d lane%0d: got ar=%0h ac=%0h br=%0h bc=%0h w=%0d, want ar=%0h ac=%0h br=%0h bc=%0h w=%0d",
                             s, beat, i, o_ar[s][i], o_ac[s][i], o_br[s][i], o_bc[s][i], o_w[s][i],
                             fr_r[top], fr_c[top], fr_r[bot], fr_c[bot], w);
                end
            end
        end
    endtask

    task automatic load_frame8(input bit gaps);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            check_idle8("load_phase");
            send_rdy = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gaps && $urandom_range(0, 1) == 0) begin
                recv_val = 1'b0;
                recv_r   = $urandom;
                recv_c   = $urandom;
            end else begin
                recv_val = 1'b1;
                recv_r   = fr_r[idx];
                recv_c   = fr_c[idx];
                idx++;
            end
        end
    endtask

    // mode 0: send_rdy=1; mode 1: 3 stall cycles on beat 0; mode 2: random stalls and recv noise.
    task automatic emit8(input int mode);
        int beat;
        int cyc;
        int hold;
        bit rdy;
        beat = 0;
        cyc = 0;
        hold = 0;
        while (beat < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            recv_val = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            recv_r   = $urandom;
            recv_c   = $urandom;
            checks++;
            if (send_val8[0] !== 1'b1 || send_val8[1] !== 1'b1 || send_val8[2] !== 1'b1 ||
                recv_rdy8[0] !== 1'b0 || recv_rdy8[1] !== 1'b0 || recv_rdy8[2] !== 1'b0) begin
                errors++;
                $display("FAIL emit_flags cycle%0d: got send_val=%b%b%b recv_rdy=%b%b%b, want 111 000",
                         cyc, send_val8[0], send_val8[1], send_val8[2],
                         recv_rdy8[0], recv_rdy8[1], recv_rdy8[2]);
            end
            check_beat8(beat);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (beat != 0) || (hold >= 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            hold++;
            if (rdy) begin
                if (mode == 1 && beat == 0) begin
                    checks++;
                    if (hold !== 4) begin
                        errors++;
                        $display("FAIL beat0_hold: got %0d cycles, want 4", hold);
                    end
                end
                beat++;
                hold = 0;
            end
            send_rdy = rdy;
        end
        if (beat < 2) begin
            errors++;
            $display("FAIL emit_timeout: got %0d beats, want 2", beat);
        end
        @(negedge clk);
        send_rdy = 1'b0;
        recv_val = 1'b0;
        check_idle8("after_emit");
        if (mode == 0) begin
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL send_val_width: got %0d cycles, want 2", cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        recv_val = 1'b0;
        recv_r = 32'd0;
        recv_c = 32'd0;
        send_rdy = 1'b0;
        bus2.recv_val = 1'b0;
        bus2.recv_r = 32'd0;
        bus2.recv_c = 32'd0;
        bus2.send_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_idle8("reset_state");
        checks++;
        if (bus2.recv_rdy !== 1'b1 || bus2.send_val !== 1'b0 || bus2.ar[0] !== 32'd0 || bus2.widx[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_n2: got recv_rdy=%b send_val=%b ar=%0h, want 1 0 0",
                     bus2.recv_rdy, bus2.send_val, bus2.ar[0]);
        end
        reset = 1'b0;
    endtask

    task automatic test_stages();
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = 32'(k);
            fr_c[k] = 32'(-k);
        end
        load_frame8(1'b0);
        emit8(0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = $urandom;
            fr_c[k] = $urandom;
        end
        load_frame8(1'b1);
        emit8(1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                fr_r[k] = $urandom;
                fr_c[k] = $urandom;
            end
            load_frame8(1'b1);
            emit8(2);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            recv_val = 1'b1;
            recv_r = $urandom;
            recv_c = $urandom;
        end
        @(negedge clk);
        recv_val = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle8("reset_in_load");
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = 32'(10 + k);
            fr_c[k] = 32'(200 + k);
        end
        load_frame8(1'b0);
        emit8(0);
        load_frame8(1'b0);
        @(negedge clk);
        recv_val = 1'b0;
        check_beat8(0);
        send_rdy = 1'b1;
        @(negedge clk);
        check_beat8(1);
        send_rdy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle8("reset_in_emit");
        load_frame8(1'b1);
        emit8(0);
    endtask

    task automatic test_n2();
        logic [31:0] q_r[$];
        logic [31:0] q_c[$];
        int beats, cyc, last, sent;
        @(negedge clk);
        bus2.recv_val = 1'b1;
        bus2.recv_r = 32'd3;
        bus2.recv_c = 32'd4;
        @(negedge clk);
        bus2.recv_r = 32'd5;
        bus2.recv_c = 32'd6;
        @(negedge clk);
        bus2.recv_val = 1'b0;
        checks++;
        if (bus2.send_val !== 1'b1 || bus2.ar[0] !== 32'd3 || bus2.ac[0] !== 32'd4 ||
            bus2.br[0] !== 32'd5 || bus2.bc[0] !== 32'd6 || bus2.widx[0] !== 1'b0) begin
            errors++;
            $display("FAIL n2_beat: got val=%b ar=%0d ac=%0d br=%0d bc=%0d w=%0d, want 1 3 4 5 6 0",
                     bus2.send_val, bus2.ar[0], bus2.ac[0], bus2.br[0], bus2.bc[0], bus2.widx[0]);
        end
        bus2.send_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus2.send_val !== 1'b0 || bus2.recv_rdy !== 1'b1) begin
            errors++;
            $display("FAIL n2_return: got send_val=%b recv_rdy=%b, want 0 1", bus2.send_val, bus2.recv_rdy);
        end
        beats = 0;
        cyc = 0;
        last = -1;
        sent = 0;
        while (beats < 6 && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (bus2.send_val === 1'b1) begin
                checks++;
                if (q_r.size() < 2 || bus2.ar[0] !== q_r[0] || bus2.ac[0] !== q_c[0] ||
                    bus2.br[0] !== q_r[1] || bus2.bc[0] !== q_c[1] || bus2.widx[0] !== 1'b0 ||
                    (last >= 0 && cyc - last != 3)) begin
                    errors++;
                    $display("FAIL n2_stream beat%0d: got ar=%0h ac=%0h br=%0h bc=%0h gap=%0d, want ar=%0h ac=%0h br=%0h bc=%0h gap=3",
                             beats, bus2.ar[0], bus2.ac[0], bus2.br[0], bus2.bc[0], cyc - last,
                             (q_r.size() > 0) ? q_r[0] : 32'd0, (q_c.size() > 0) ? q_c[0] : 32'd0,
                             (q_r.size() > 1) ? q_r[1] : 32'd0, (q_c.size() > 1) ? q_c[1] : 32'd0);
                end
                if (q_r.size() >= 2) begin
                    void'(q_r.pop_front());
                    void'(q_r.pop_front());
                    void'(q_c.pop_front());
                    void'(q_c.pop_front());
                end
                last = cyc;
                beats++;
            end
            bus2.recv_r = $urandom;
            bus2.recv_c = $urandom;
            if (bus2.recv_rdy === 1'b1) begin
                bus2.recv_val = (sent < 12);
                if (sent < 12) begin
                    q_r.push_back(bus2.recv_r);
                    q_c.push_back(bus2.recv_c);
                    sent++;
                end
            end else begin
                bus2.recv_val = 1'b1;
            end
        end
        if (beats < 6) begin
            errors++;
            $display("FAIL n2_timeout: got %0d beats, want 6", beats);
        end
        bus2.recv_val = 1'b0;
        bus2.send_rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stages();
        test_backpressure();
        test_random_frames();
        test_reset_mid_frame();
        test_n2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
